alu_seq_unit: RTL

//  Handshaked, registered ALU execution unit. It is the responder that the ALU stimulus/check

---
 rtl/alu_seq_unit_if.sv | 29 ++
 rtl/alu_seq_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_unit_if.sv
// alu_seq_unit_if: operand/opcode input channel and result/flag output channel
// for alu_seq_unit. The master drives operands and out_ready; the slave is the ALU.
interface alu_seq_unit_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             overflow;
  logic             err;
  logic             busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zero, carry, overflow, err, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zero, carry, overflow, err, busy
  );
endinterface

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: handshaked, registered ALU. Logic/arith ops complete in one cycle;
// shifts iterate one bit per cycle in a small FSM. Defining ALU_SEQ_MUL_EN adds a
// WIDTH-cycle unsigned shift-add multiplier on op 10; otherwise op 10 reports err.
module alu_seq_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic         clk,
  input logic         rst,
  alu_seq_unit_if.slave bus
);
  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = SHW + 1;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd10;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_MUL} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT} state_t;
`endif

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sh_val;
  logic [3:0]       sh_op;
  logic             busy_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             carry_q;
  logic             overflow_q;
  logic             err_q;

  logic             in_ready;
  logic             in_fire;
  logic [SHW-1:0]   shamt;
  logic             is_shift;
  logic             shift_start;
  logic             multi_start;
  logic             last;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] f_result;
  logic             f_carry;
  logic             f_ovf;
  logic             f_err;

  logic [WIDTH-1:0] sh_next;
  logic             sh_out;

  logic             load;
  logic [WIDTH-1:0] ld_result;
  logic             ld_carry;
  logic             ld_ovf;
  logic             ld_err;

`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] mc;
  logic [WIDTH-1:0] mp;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
`endif

  // Accept only when idle and the output slot is free or draining this cycle.
  assign in_ready    = (state == ST_IDLE) && (!out_valid_q || bus.out_ready);
  assign in_fire     = bus.in_valid && in_ready;
  assign shamt       = bus.b[SHW-1:0];
  assign is_shift    = (bus.op == OP_SLL) || (bus.op == OP_SRL) || (bus.op == OP_SRA);
  assign shift_start = is_shift && (shamt != '0);
  assign last        = (cnt == CW'(1));
`ifdef ALU_SEQ_MUL_EN
  assign multi_start = shift_start || (bus.op == OP_MUL);
  assign acc_next    = mp[0] ? (acc + mc) : acc;
`else
  assign multi_start = shift_start;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = overflow_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;

  // Single-cycle datapath; shift ops land here only with a zero shift amount.
  always_comb begin
    sum      = {1'b0, bus.a} + {1'b0, bus.b};
    diff     = {1'b0, bus.a} - {1'b0, bus.b};
    f_result = '0;
    f_carry  = 1'b0;
    f_ovf    = 1'b0;
    f_err    = 1'b0;
    case (bus.op)
      OP_AND:  f_result = bus.a & bus.b;
      OP_OR:   f_result = bus.a | bus.b;
      OP_XOR:  f_result = bus.a ^ bus.b;
      OP_ADD: begin
        f_result = sum[WIDTH-1:0];
        f_carry  = sum[WIDTH];
        f_ovf    = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        f_result = diff[WIDTH-1:0];
        f_carry  = diff[WIDTH];
        f_ovf    = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SLT:  f_result = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLTU: f_result = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      OP_SLL, OP_SRL, OP_SRA: f_result = bus.a;
      default: f_err = 1'b1;
    endcase
  end

  // One-bit shift step; sh_out is the bit leaving the register this step.
  always_comb begin
    sh_next = sh_val;
    sh_out  = 1'b0;
    case (sh_op)
      OP_SLL: begin
        sh_next = {sh_val[WIDTH-2:0], 1'b0};
        sh_out  = sh_val[WIDTH-1];
      end
      OP_SRL: begin
        sh_next = {1'b0, sh_val[WIDTH-1:1]};
        sh_out  = sh_val[0];
      end
      OP_SRA: begin
        sh_next = {sh_val[WIDTH-1], sh_val[WIDTH-1:1]};
        sh_out  = sh_val[0];
      end
      default: sh_next = sh_val;
    endcase
  end

  // Select what loads into the output register and when.
  always_comb begin
    load      = 1'b0;
    ld_result = f_result;
    ld_carry  = f_carry;
    ld_ovf    = f_ovf;
    ld_err    = f_err;
    case (state)
      ST_IDLE:  load = in_fire && !multi_start;
      ST_SHIFT: begin
        load      = last;
        ld_result = sh_next;
        ld_carry  = sh_out;
        ld_ovf    = 1'b0;
        ld_err    = 1'b0;
      end
`ifdef ALU_SEQ_MUL_EN
      ST_MUL: begin
        load      = last;
        ld_result = acc_next;
        ld_carry  = 1'b0;
        ld_ovf    = 1'b0;
        ld_err    = 1'b0;
      end
`endif
      default:  load = 1'b0;
    endcase
  end

  // Control FSM with iteration counter and registered busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      sh_val <= '0;
      sh_op  <= '0;
      busy_q <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mc     <= '0;
      mp     <= '0;
      acc    <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_fire && shift_start) begin
            state  <= ST_SHIFT;
            cnt    <= CW'(shamt);
            sh_val <= bus.a;
            sh_op  <= bus.op;
            busy_q <= 1'b1;
          end
`ifdef ALU_SEQ_MUL_EN
          else if (in_fire && (bus.op == OP_MUL)) begin
            state  <= ST_MUL;
            cnt    <= CW'(WIDTH);
            mc     <= bus.a;
            mp     <= bus.b;
            acc    <= '0;
            busy_q <= 1'b1;
          end
`endif
        end
        ST_SHIFT: begin
          sh_val <= sh_next;
          cnt    <= cnt - CW'(1);
          if (last) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        end
`ifdef ALU_SEQ_MUL_EN
        ST_MUL: begin
          acc <= acc_next;
          mc  <= {mc[WIDTH-2:0], 1'b0};
          mp  <= {1'b0, mp[WIDTH-1:1]};
          cnt <= cnt - CW'(1);
          if (last) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        end
`endif
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Output register: load sets valid, a transfer without a fresh load clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      err_q       <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      result_q    <= ld_result;
      zero_q      <= (ld_result == '0);
      carry_q     <= ld_carry;
      overflow_q  <= ld_ovf;
      err_q       <= ld_err;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
endmodule
